// File: rtl/coin_accumulator.sv
// Coin intake: saturating credit total, cancel/vend refund via held change handshake.
// Latency: one cycle from any input event to registered outputs.
// Backpressure: change_valid/change_amt held until change_ack; coins rejected while busy.
// Optional idle refund enabled by defining COIN_TIMEOUT_EN.
module coin_accumulator #(
  parameter int MAX_PAID       = 31,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic       vend_done,
  input  logic [3:0] price,
  input  logic       change_ack,
  output logic [4:0] paid,
  output logic       coin_reject,
  output logic       change_valid,
  output logic [4:0] change_amt,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, CHANGE} state_t;

  state_t     state;
  logic [5:0] coin_val;
  logic [5:0] sum;
  logic [4:0] remainder;
  logic       fits;
  logic       vend_ok;
  logic       cancel_ok;
  logic       coin_ok;
  logic       timeout_hit;

  // Decode the coin denomination into units
  always_comb begin
    coin_val = 6'd1;
    case (coin_type)
      2'b00:   coin_val = 6'd1;
      2'b01:   coin_val = 6'd2;
      2'b10:   coin_val = 6'd5;
      default: coin_val = 6'd10;
    endcase
  end

  // Sum is one bit wider than paid so an overflowing coin is detected, not wrapped
  assign sum       = {1'b0, paid} + coin_val;
  assign fits      = (sum <= 6'(MAX_PAID));
  assign remainder = paid - {1'b0, price};
  assign vend_ok   = vend_done && (state == COLLECT) && (paid >= {1'b0, price});
  assign cancel_ok = cancel && (state == COLLECT);
  // Any coin coinciding with a vend or cancel strobe is bounced rather than silently dropped
  assign coin_ok   = coin_valid && (state != CHANGE) && !vend_done && !cancel && fits;

`ifdef COIN_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] idle_cnt;

  // Terminal count with no competing event turns into an internal cancel
  assign timeout_hit = (state == COLLECT) && (idle_cnt == CW'(TIMEOUT_CYCLES - 1)) &&
                       !coin_valid && !cancel && !vend_done;

  // Count cycles spent in COLLECT without a credited coin; anything else restarts it
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if ((state == COLLECT) && !coin_ok && !vend_ok && !cancel_ok &&
                 (idle_cnt != CW'(TIMEOUT_CYCLES - 1))) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Main control: priority is reset, vend, cancel/timeout, then coin
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      paid         <= '0;
      coin_reject  <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      busy         <= 1'b0;
    end else begin
      coin_reject <= coin_valid && !coin_ok;
      case (state)
        CHANGE: begin
          if (change_ack) begin
            change_valid <= 1'b0;
            change_amt   <= '0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          if (vend_ok) begin
            paid <= '0;
            if (remainder != 5'd0) begin
              change_amt   <= remainder;
              change_valid <= 1'b1;
              busy         <= 1'b1;
              state        <= CHANGE;
            end else begin
              state <= IDLE;
            end
          end else if (cancel_ok || timeout_hit) begin
            change_amt   <= paid;
            paid         <= '0;
            change_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= CHANGE;
          end else if (coin_ok) begin
            paid  <= sum[4:0];
            state <= COLLECT;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/coin_accumulator.md
# coin_accumulator

Clocked coin-intake stage for the vending datapath. It accepts coin events, keeps a saturating running total, and drives that total as `paid` into the payment validator. On cancel or on completion of a vend it returns the unspent balance through a held change handshake. It is the sole owner of the customer's credit between insertion and dispense.

## Interface
Parameters:
- `MAX_PAID`, default 31: credit ceiling; must be ≤ 31 to fit `paid`.
- `TIMEOUT_CYCLES`, default 255: idle cycles before an automatic refund; used only when `COIN_TIMEOUT_EN` is defined.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous reset, active-low (`rst`=0 resets on the next rising edge).
- `coin_valid` input 1: one-cycle coin-insert strobe.
- `coin_type` input 2: coin value; 00=1, 01=2, 10=5, 11=10 units.
- `cancel` input 1: customer refund request, sampled each cycle.
- `vend_done` input 1: one-cycle pulse from dispense; the item at `price` was delivered.
- `price` input 4: price of the selected item; sampled only with `vend_done`.
- `change_ack` input 1: change mechanism has taken `change_amt`.
- `paid` output 5: current credit, registered; feeds the validator.
- `coin_reject` output 1: one-cycle pulse; the sampled coin was not credited.
- `change_valid` output 1: change pending; held until acknowledged.
- `change_amt` output 5: amount to return; stable while `change_valid`=1.
- `busy` output 1: high in the CHANGE state; the coin path is closed.

## Operation
- Reset (`rst`=0):
  - `paid`=0, `coin_reject`=0, `change_valid`=0, `change_amt`=0, `busy`=0.
  - State goes to IDLE.
  - A reset in any state, including CHANGE with change pending, discards credit and change.
- States:
  - IDLE: `paid`=0.
  - COLLECT: `paid`>0.
  - CHANGE: `change_valid`=1, `busy`=1.
- Coin in IDLE or COLLECT:
  - Zero-extend the coin value to 6 bits and add it to `paid`.
  - If the sum is ≤ `MAX_PAID`: `paid` becomes the sum and the state is COLLECT.
  - Otherwise: `paid` is unchanged and `coin_reject` pulses.
- Coin in CHANGE: always rejected (`coin_reject` pulse).
- Cancel in COLLECT:
  - `change_amt` ← `paid`, `paid` ← 0, `change_valid` ← 1, state → CHANGE.
- Cancel in IDLE or CHANGE: no effect.
- `vend_done` in COLLECT with `paid` ≥ `price`:
  - Remainder r = `paid` − `price`; `paid` ← 0.
  - If r>0: `change_amt` ← r, state → CHANGE.
  - If r=0: state → IDLE with no change cycle.
- `vend_done` with `paid` < `price`, or in IDLE: ignored, no state change.
- `vend_done` in CHANGE: ignored.
- CHANGE state:
  - On `change_ack`=1: `change_valid` ← 0, `change_amt` ← 0, state → IDLE.
  - Without `change_ack`: outputs hold indefinitely.
- Priority when events coincide in one cycle: `rst` > `vend_done` > `cancel` > coin.
  - A coin arriving with `vend_done` or `cancel` is rejected (`coin_reject` pulse), never lost silently.
  - `cancel` arriving with a valid `vend_done` is dropped; the remainder is refunded anyway.

## Timing
- All outputs are registered.
- Coin strobe at edge N: `paid`/`coin_reject` update at edge N+1.
- Cancel or `vend_done` at edge N: `paid`=0, plus `change_valid`/`change_amt` where applicable, at edge N+1.
- `change_ack` at edge N: `change_valid`=0 at edge N+1.
  - Earliest new coin acceptance is at edge N+1, credited at N+2.
- `coin_reject` is exactly one cycle wide per rejected coin.
  - Back-to-back rejected coins give back-to-back pulses.
- `change_ack` while `change_valid`=0 is ignored.
- `paid` never exceeds `MAX_PAID` and never wraps.

## Configuration
- `COIN_TIMEOUT_EN` defined:
  - An idle counter is cleared on reset, on each credited coin, and on leaving COLLECT.
  - It increments every cycle in COLLECT.
  - When it reaches `TIMEOUT_CYCLES`−1 with no coin, cancel, or `vend_done` that cycle, the block performs an internal cancel on the next edge: identical outputs to a customer cancel.
  - A coin, cancel, or vend in the terminal cycle takes priority and clears the counter.
- `COIN_TIMEOUT_EN` undefined:
  - No counter is built; credit is held in COLLECT indefinitely.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset then coins 5, 10, 2 → `paid` = 5, 15, 17 on successive cycles; `coin_reject` stays 0.
- `paid`=25, coin 10 → `paid` stays 25, `coin_reject` is a 1-cycle pulse.
  - Then coin 5 → `paid`=30, then coin 1 → `paid`=31.
- `paid`=17, `vend_done` with `price`=12 → next cycle `paid`=0, `change_valid`=1, `change_amt`=5.
  - Hold `change_ack` low for 4 cycles → outputs stable; ack → `change_valid`=0, IDLE.
- `paid`=9, `vend_done` with `price`=9 → `paid`=0, `change_valid` never asserts.
  - `vend_done` with `paid`=3, `price`=9 → ignored, `paid` stays 3.
- `paid`=8, cancel and coin 2 in the same cycle → `change_amt`=8, `coin_reject` pulse.
  - A coin during CHANGE → rejected.
  - `rst`=0 while in CHANGE → all outputs 0 next cycle.
- With `COIN_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8: coin 5, then idle → `change_valid`=1, `change_amt`=5, exactly 8 cycles after the credited coin.
  - A coin at idle cycle 6 restarts the count.
